// File: rtl/periphery_io_ctrl_if.sv
// Memory-side bus between the IO controller (master) and the core memory (slave).
// Latency: none, wires only; the controller registers every master-driven signal.
// Backpressure: none; mem_rd_valid returns read data at any latency >= 1 cycle.
//
// Signals: mem_wr_en/mem_rd_en single-cycle strobes, mem_addr word address,
// mem_wr_data write word, mem_rd_data/mem_rd_valid read return.
interface periphery_io_ctrl_if #(
   parameter int MEM_DATA_L = 64,
   parameter int MEM_ADDR_L = 16
);
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [MEM_ADDR_L-1:0] mem_addr;
   logic [MEM_DATA_L-1:0] mem_wr_data;
   logic [MEM_DATA_L-1:0] mem_rd_data;
   logic                  mem_rd_valid;

   modport master (
      output mem_wr_en, mem_rd_en, mem_addr, mem_wr_data,
      input  mem_rd_data, mem_rd_valid
   );

   modport slave (
      input  mem_wr_en, mem_rd_en, mem_addr, mem_wr_data,
      output mem_rd_data, mem_rd_valid
   );
endinterface

// File: rtl/periphery_io_ctrl.sv
// Core-side IO controller: decodes host opcodes, packs pad half-words into memory words, serves read-back, registers exec handshake.
// Latency: 1 cycle from opcode/exec inputs to registered outputs; read data appears 1 cycle after mem_rd_valid.
// Backpressure: none; commands that cannot be served (read in flight, mixed halves, core executing) are dropped and flag err.
//
// Ports: clk/rst (async active-low); in_data/io_opcode host command; reset_/enable_execution_io host
// exec controls; done_execution_io sticky done; out_data read/status word; exec_reset/exec_enable/exec_done
// core handshake; mem memory bus (master side).
module periphery_io_ctrl #(
   parameter int INPUT_DATA_L  = 32,
   parameter int OUTPUT_DATA_L = 32,
   parameter int IO_OPCODE_L   = 3,
   parameter int MEM_DATA_L    = 64,
   parameter int MEM_ADDR_L    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INPUT_DATA_L-1:0]  in_data,
   input  logic [IO_OPCODE_L-1:0]   io_opcode,
   input  logic                     reset_execution_io,
   input  logic                     enable_execution_io,
   output logic                     done_execution_io,
   output logic [OUTPUT_DATA_L-1:0] out_data,
   output logic                     exec_reset,
   output logic                     exec_enable,
   input  logic                     exec_done,
   periphery_io_ctrl_if.master      mem
);

   localparam logic [IO_OPCODE_L-1:0] OP_SET_ADDR = IO_OPCODE_L'(1);
   localparam logic [IO_OPCODE_L-1:0] OP_WR_HALF  = IO_OPCODE_L'(2);
   localparam logic [IO_OPCODE_L-1:0] OP_RD_HALF  = IO_OPCODE_L'(3);
   localparam logic [IO_OPCODE_L-1:0] OP_STATUS   = IO_OPCODE_L'(4);

   logic [MEM_ADDR_L-1:0]   addr;
   logic                    half;
   logic                    half_rd;     // half=1 was reached by a read (vs. a write)
   logic [INPUT_DATA_L-1:0] wr_lo;
   logic                    rd_pending;
   // Only the upper half of a read word is ever replayed; the lower half goes straight to out_data.
   logic [INPUT_DATA_L-1:0] rd_buf_hi;
   logic                    err;

   logic                     is_wr, is_rd, is_bad;
   logic                     mem_blocked;
   logic                     wr_drop, rd_drop, cmd_err;
   logic [OUTPUT_DATA_L-1:0] status_word;

   always_comb begin
      is_wr       = (io_opcode == OP_WR_HALF);
      is_rd       = (io_opcode == OP_RD_HALF);
      is_bad      = (io_opcode > OP_STATUS);
      // Memory is owned by the core while executing; also only one read may be outstanding.
      mem_blocked = rd_pending | exec_enable;
      wr_drop     = mem_blocked | (half & half_rd);
      rd_drop     = mem_blocked | (half & ~half_rd);
      cmd_err     = (is_wr & wr_drop) | (is_rd & rd_drop) | is_bad;

      // OUTPUT_DATA_L must be at least MEM_ADDR_L+4 to hold the status fields.
      status_word                 = '0;
      status_word[MEM_ADDR_L-1:0] = addr;
      status_word[MEM_ADDR_L]     = done_execution_io;
      status_word[MEM_ADDR_L+1]   = half;
      status_word[MEM_ADDR_L+2]   = rd_pending;
      status_word[MEM_ADDR_L+3]   = err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr              <= '0;
         half              <= 1'b0;
         half_rd           <= 1'b0;
         wr_lo             <= '0;
         rd_pending        <= 1'b0;
         rd_buf_hi         <= '0;
         err               <= 1'b0;
         out_data          <= '0;
         exec_reset        <= 1'b0;
         exec_enable       <= 1'b0;
         done_execution_io <= 1'b0;
         mem.mem_wr_en     <= 1'b0;
         mem.mem_rd_en     <= 1'b0;
         mem.mem_addr      <= '0;
         mem.mem_wr_data   <= '0;
      end else begin
         mem.mem_wr_en <= 1'b0;
         mem.mem_rd_en <= 1'b0;

         exec_reset  <= reset_execution_io;
         exec_enable <= enable_execution_io & ~reset_execution_io;
         if (reset_execution_io)
            done_execution_io <= 1'b0;
         else if (exec_done && exec_enable)
            done_execution_io <= 1'b1;

         // STATUS clears err, but any error raised by this cycle's command still sticks.
         err <= (err & ~(io_opcode == OP_STATUS)) | cmd_err;

         if (rd_pending && mem.mem_rd_valid) begin
            rd_buf_hi  <= mem.mem_rd_data[MEM_DATA_L-1:INPUT_DATA_L];
            out_data   <= mem.mem_rd_data[INPUT_DATA_L-1:0];
            rd_pending <= 1'b0;
            half       <= 1'b1;
            half_rd    <= 1'b1;
         end

         // Opcode handling comes last so SET_ADDR cancels a read returning in the same cycle,
         // and a same-cycle STATUS takes out_data over the returning read data.
         case (io_opcode)
            OP_SET_ADDR: begin
               addr       <= in_data[MEM_ADDR_L-1:0];
               half       <= 1'b0;
               rd_pending <= 1'b0;
            end
            OP_WR_HALF: begin
               if (!wr_drop) begin
                  if (!half) begin
                     wr_lo   <= in_data;
                     half    <= 1'b1;
                     half_rd <= 1'b0;
                  end else begin
                     mem.mem_wr_en   <= 1'b1;
                     mem.mem_addr    <= addr;
                     mem.mem_wr_data <= {in_data, wr_lo};
                     addr            <= addr + MEM_ADDR_L'(1);
                     half            <= 1'b0;
                  end
               end
            end
            OP_RD_HALF: begin
               if (!rd_drop) begin
                  if (!half) begin
                     mem.mem_rd_en <= 1'b1;
                     mem.mem_addr  <= addr;
                     rd_pending    <= 1'b1;
                  end else begin
                     out_data <= rd_buf_hi;
                     addr     <= addr + MEM_ADDR_L'(1);
                     half     <= 1'b0;
                  end
               end
            end
            OP_STATUS: out_data <= status_word;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_periphery_io_ctrl.sv
module tb_periphery_io_ctrl;

   localparam logic [2:0] OP_NOP = 3'd0, OP_SET = 3'd1, OP_WR = 3'd2, OP_RD = 3'd3, OP_STAT = 3'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_data = '0;
   logic [2:0]  io_opcode = OP_NOP;
   logic        reset_execution_io = 1'b0;
   logic        enable_execution_io = 1'b0;
   logic        done_execution_io;
   logic [31:0] out_data;
   logic        exec_reset, exec_enable;
   logic        exec_done = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int rd_base;

   periphery_io_ctrl_if #(.MEM_DATA_L(64), .MEM_ADDR_L(16)) mem ();

   periphery_io_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_data             (in_data),
      .io_opcode           (io_opcode),
      .reset_execution_io  (reset_execution_io),
      .enable_execution_io (enable_execution_io),
      .done_execution_io   (done_execution_io),
      .out_data            (out_data),
      .exec_reset          (exec_reset),
      .exec_enable         (exec_enable),
      .exec_done           (exec_done),
      .mem                 (mem.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem.mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (mem.mem_rd_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [2:0] op, input logic [31:0] d);
      io_opcode = op;
      in_data   = d;
      cyc();
      io_opcode = OP_NOP;
      in_data   = '0;
   endtask

   task automatic test_reset();
      mem.mem_rd_data  = '0;
      mem.mem_rd_valid = 1'b0;
      rst = 1'b0;
      repeat (2) cyc();
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
      n_cmp++; if ({mem.mem_wr_en, mem.mem_rd_en} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes got %b want 00", {mem.mem_wr_en, mem.mem_rd_en}); end
      n_cmp++; if (mem.mem_addr !== 16'h0 || mem.mem_wr_data !== 64'h0) begin n_bad++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem.mem_addr, mem.mem_wr_data); end
      n_cmp++; if ({exec_reset, exec_enable, done_execution_io} !== 3'b000) begin n_bad++; $display("FAIL rst_exec got %b want 000", {exec_reset, exec_enable, done_execution_io}); end
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_write();
      cmd(OP_SET, 32'h0000_0010);
      cmd(OP_WR, 32'hAAAA_5555);
      n_cmp++; if (mem.mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL wr_first_half got %b want 0", mem.mem_wr_en); end
      cmd(OP_WR, 32'h1234_5678);
      n_cmp++; if (mem.mem_wr_en !== 1'b1) begin n_bad++; $display("FAIL wr_strobe got %b want 1", mem.mem_wr_en); end
      n_cmp++; if (mem.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL wr_addr got %h want 0010", mem.mem_addr); end
      n_cmp++; if (mem.mem_wr_data !== 64'h1234_5678_AAAA_5555) begin n_bad++; $display("FAIL wr_data got %h want 12345678aaaa5555", mem.mem_wr_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (mem.mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL wr_one_cycle got %b want 0", mem.mem_wr_en); end
      n_cmp++; if (out_data !== 32'h0000_0011) begin n_bad++; $display("FAIL wr_status got %h want 00000011", out_data); end
      n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL wr_count got %0d want 1", wr_cnt); end
   endtask

   task automatic test_read();
      rd_base = rd_cnt;
      cmd(OP_SET, 32'h0000_0010);
      cmd(OP_RD, 32'h0);
      n_cmp++; if (mem.mem_rd_en !== 1'b1 || mem.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL rd_issue got en=%b addr=%h want en=1 addr=0010", mem.mem_rd_en, mem.mem_addr); end
      cyc();
      cyc();
      mem.mem_rd_data  = 64'h1234_5678_AAAA_5555;
      mem.mem_rd_valid = 1'b1;
      cyc();
      mem.mem_rd_valid = 1'b0;
      mem.mem_rd_data  = '0;
      n_cmp++; if (out_data !== 32'hAAAA_5555) begin n_bad++; $display("FAIL rd_low got %h want aaaa5555", out_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0002_0010) begin n_bad++; $display("FAIL rd_status_half got %h want 00020010", out_data); end
      cmd(OP_RD, 32'h0);
      n_cmp++; if (out_data !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_high got %h want 12345678", out_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0000_0011) begin n_bad++; $display("FAIL rd_status_end got %h want 00000011", out_data); end
      n_cmp++; if (rd_cnt - rd_base !== 1) begin n_bad++; $display("FAIL rd_count got %0d want 1", rd_cnt - rd_base); end
   endtask

   task automatic test_wrap();
      cmd(OP_SET, 32'h0000_FFFF);
      cmd(OP_WR, 32'h0BAD_F00D);
      cmd(OP_WR, 32'hC0DE_0001);
      n_cmp++; if (mem.mem_wr_en !== 1'b1 || mem.mem_addr !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_write got en=%b addr=%h want en=1 addr=ffff", mem.mem_wr_en, mem.mem_addr); end
      n_cmp++; if (mem.mem_wr_data !== 64'hC0DE_0001_0BAD_F00D) begin n_bad++; $display("FAIL wrap_data got %h want c0de00010badf00d", mem.mem_wr_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_status got %h want 00000000", out_data); end
   endtask

   task automatic test_cancel();
      cmd(OP_RD, 32'h0);
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0004_0000) begin n_bad++; $display("FAIL cancel_pending got %h want 00040000", out_data); end
      cmd(OP_SET, 32'h0000_0005);
      mem.mem_rd_data  = 64'hDEAD_BEEF_CAFE_F00D;
      mem.mem_rd_valid = 1'b1;
      cyc();
      mem.mem_rd_valid = 1'b0;
      mem.mem_rd_data  = '0;
      n_cmp++; if (out_data !== 32'h0004_0000) begin n_bad++; $display("FAIL cancel_late_data got %h want 00040000", out_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0000_0005) begin n_bad++; $display("FAIL cancel_status got %h want 00000005", out_data); end
   endtask

   task automatic test_mix();
      cmd(OP_WR, 32'h1111_1111);
      cmd(OP_RD, 32'h0);
      n_cmp++; if (mem.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL mix_no_read got %b want 0", mem.mem_rd_en); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h000A_0005) begin n_bad++; $display("FAIL mix_status_err got %h want 000a0005", out_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0002_0005) begin n_bad++; $display("FAIL mix_status_clr got %h want 00020005", out_data); end
      cmd(OP_SET, 32'h0000_0030);
   endtask

   task automatic test_exec_err();
      enable_execution_io = 1'b1;
      cyc();
      n_cmp++; if (exec_enable !== 1'b1) begin n_bad++; $display("FAIL exec_en_rise got %b want 1", exec_enable); end
      cmd(OP_WR, 32'h2222_2222);
      cmd(OP_WR, 32'h3333_3333);
      n_cmp++; if (mem.mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL exec_wr_blocked got %b want 0", mem.mem_wr_en); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0008_0030) begin n_bad++; $display("FAIL exec_status_err got %h want 00080030", out_data); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0000_0030) begin n_bad++; $display("FAIL exec_status_clr got %h want 00000030", out_data); end
   endtask

   task automatic test_exec_done();
      exec_done = 1'b1;
      cyc();
      exec_done = 1'b0;
      n_cmp++; if (done_execution_io !== 1'b1) begin n_bad++; $display("FAIL done_set got %b want 1", done_execution_io); end
      repeat (2) cyc();
      n_cmp++; if (done_execution_io !== 1'b1) begin n_bad++; $display("FAIL done_held got %b want 1", done_execution_io); end
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0001_0030) begin n_bad++; $display("FAIL done_status got %h want 00010030", out_data); end
      reset_execution_io = 1'b1;
      cyc();
      n_cmp++; if ({done_execution_io, exec_enable, exec_reset} !== 3'b001) begin n_bad++; $display("FAIL done_clear got %b want 001", {done_execution_io, exec_enable, exec_reset}); end
      reset_execution_io  = 1'b0;
      enable_execution_io = 1'b0;
      cyc();
      exec_done = 1'b1;
      cyc();
      exec_done = 1'b0;
      n_cmp++; if (done_execution_io !== 1'b0) begin n_bad++; $display("FAIL done_ignored got %b want 0", done_execution_io); end
      enable_execution_io = 1'b1;
      cyc();
      exec_done          = 1'b1;
      reset_execution_io = 1'b1;
      cyc();
      exec_done          = 1'b0;
      reset_execution_io = 1'b0;
      enable_execution_io = 1'b0;
      n_cmp++; if (done_execution_io !== 1'b0) begin n_bad++; $display("FAIL done_clear_wins got %b want 0", done_execution_io); end
      cyc();
   endtask

   task automatic test_bad_opcode();
      cmd(3'd6, 32'h0);
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0008_0030) begin n_bad++; $display("FAIL badop_err got %h want 00080030", out_data); end
   endtask

   task automatic test_reset_mid_read();
      cmd(OP_SET, 32'h0000_0040);
      cmd(OP_RD, 32'h0);
      n_cmp++; if (mem.mem_rd_en !== 1'b1 || mem.mem_addr !== 16'h0040) begin n_bad++; $display("FAIL midrst_issue got en=%b addr=%h want en=1 addr=0040", mem.mem_rd_en, mem.mem_addr); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if ({mem.mem_rd_en, mem.mem_addr} !== 17'h0) begin n_bad++; $display("FAIL midrst_mem got en=%b addr=%h want 0/0", mem.mem_rd_en, mem.mem_addr); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL midrst_out got %h want 0", out_data); end
      rst = 1'b1;
      cyc();
      cmd(OP_STAT, 32'h0);
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL midrst_status got %h want 0", out_data); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_cancel();
      test_mix();
      test_exec_err();
      test_exec_done();
      test_bad_opcode();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/periphery_io_ctrl.md
Name: periphery_io_ctrl

Overview:
Core-side IO controller that sits directly downstream of the pad wrapper. It decodes the per-cycle host opcode and assembles narrow pad words into full-width memory writes. It serves memory read-back through the narrow output bus. It also registers the execution reset/enable/done handshake between the pads and the DAG-processing core.

Parameters:
INPUT_DATA_L, 32, pad input data width
OUTPUT_DATA_L, 32, pad output data width (must equal INPUT_DATA_L)
IO_OPCODE_L, 3, opcode width
MEM_DATA_L, 64, memory word width (= 2*INPUT_DATA_L)
MEM_ADDR_L, 16, memory word address width

Ports:
clk  in  1  core clock (from pad wrapper)
rst  in  1  asynchronous, active-low reset
in_data  in  INPUT_DATA_L  host data from pads
io_opcode  in  IO_OPCODE_L  host opcode, sampled every cycle
reset_execution_io  in  1  host execution reset
enable_execution_io  in  1  host execution enable
done_execution_io  out  1  sticky execution-done to pads
out_data  out  OUTPUT_DATA_L  registered read/status data to pads
exec_reset  out  1  registered execution reset to core
exec_enable  out  1  registered execution enable to core
exec_done  in  1  single-cycle done pulse from core
mem_wr_en  out  1  memory write strobe
mem_rd_en  out  1  memory read strobe
mem_addr  out  MEM_ADDR_L  memory word address
mem_wr_data  out  MEM_DATA_L  memory write data
mem_rd_data  in  MEM_DATA_L  memory read data
mem_rd_valid  in  1  mem_rd_data valid, arbitrary latency >= 1 cycle after mem_rd_en

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. addr=0, half=0, wr_lo=0, rd_pending=0, rd_buf=0, err=0.
- Opcodes: 0 NOP, 1 SET_ADDR, 2 WR_HALF, 3 RD_HALF, 4 STATUS. Codes 5-7 behave as NOP and set err.
- SET_ADDR: addr<=in_data[MEM_ADDR_L-1:0], half<=0, rd_pending<=0. A read in flight is cancelled: its mem_rd_valid is ignored.
- WR_HALF, half=0: wr_lo<=in_data, half<=1, no memory access.
- WR_HALF, half=1: next cycle mem_wr_en=1 for one cycle, mem_wr_data={in_data, wr_lo}, mem_addr=addr. Then addr<=addr+1 and half<=0.
- RD_HALF, half=0: next cycle mem_rd_en=1 for one cycle at addr, rd_pending<=1. On the mem_rd_valid cycle with rd_pending=1: rd_buf<=mem_rd_data, out_data<=mem_rd_data[31:0] (visible the following cycle), rd_pending<=0, half<=1.
- RD_HALF, half=1, rd_pending=0: out_data<=rd_buf[63:32], addr<=addr+1, half<=0. No memory access.
- Any RD_HALF or WR_HALF while rd_pending=1: dropped, err<=1.
- A mix of WR and RD halves (WR_HALF while half=1 came from a read, or vice versa): command dropped, err<=1, half unchanged.
- WR_HALF or RD_HALF while exec_enable=1: dropped, err<=1; the memory belongs to the core during execution.
- Address wraps from 2^MEM_ADDR_L-1 to 0 silently.
- STATUS: out_data<={zero-pad, err, rd_pending, half, done_execution_io, addr}, with addr in the LSBs. Reading STATUS clears err in the same update; an error raised in the same cycle wins.
- out_data holds its value until the next read-data or STATUS update.
- exec_reset <= reset_execution_io. exec_enable <= enable_execution_io & ~reset_execution_io. Latency 1 cycle.
- done_execution_io: set the cycle after exec_done=1. Cleared the cycle after reset_execution_io=1; clear wins if both occur together. Held while exec_enable stays high.
- exec_done while exec_enable=0 is ignored.

Test Plan:
- SET_ADDR 0x0010; WR_HALF 0xAAAA5555; WR_HALF 0x12345678 -> one mem_wr_en pulse with addr 0x0010, data 0x12345678AAAA5555; STATUS shows addr 0x0011, half 0.
- SET_ADDR 0x0010; RD_HALF; memory returns 0x12345678AAAA5555 after 3 cycles -> out_data=0xAAAA5555. Second RD_HALF -> out_data=0x12345678, addr=0x0011, exactly one mem_rd_en.
- SET_ADDR 0xFFFF; two WR_HALF -> write at 0xFFFF, addr wraps to 0x0000.
- RD_HALF, then SET_ADDR 0x0005 before mem_rd_valid -> late data ignored, out_data unchanged, STATUS rd_pending=0, addr 0x0005.
- enable_execution_io=1 then WR_HALF -> no mem_wr_en, STATUS err=1; a second STATUS -> err=0.
- enable=1, exec_done pulse -> done_execution_io=1 next cycle and held. reset_execution_io=1 -> done=0 and exec_enable=0 next cycle. Asserting rst mid-read clears all outputs immediately.
